// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-controller bus: core control, branch-target LUT writes and ROM fetch path.
interface inst_fetch_ctrl_if #(
    parameter int A = 10,
    parameter int W = 9
);
    logic         Start;
    logic [A-1:0] StartAddr;
    logic         Stall;
    logic         BranchTaken;
    logic [2:0]   BranchIdx;
    logic         LutWe;
    logic [2:0]   LutIdx;
    logic [A-1:0] LutData;
    logic [W-1:0] InstIn;
    logic [A-1:0] InstAddress;
    logic         InstValid;
    logic         Busy;
    logic         Done;
    logic [15:0]  InstCount;

    modport master (
        output Start, StartAddr, Stall, BranchTaken, BranchIdx,
               LutWe, LutIdx, LutData, InstIn,
        input  InstAddress, InstValid, Busy, Done, InstCount
    );

    modport slave (
        input  Start, StartAddr, Stall, BranchTaken, BranchIdx,
               LutWe, LutIdx, LutData, InstIn,
        output InstAddress, InstValid, Busy, Done, InstCount
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: drives the ROM PC, follows LUT branch targets,
// stops on the all-ones halt word and counts retired instructions.
//
// state | meaning
// IDLE  | waiting for Start after reset
// RUN   | fetching; PC advances each unstalled cycle
// HALT  | halt word seen; waiting for Start to rerun
module inst_fetch_ctrl #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic             Clk,
    input  logic             Reset,
    inst_fetch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [A-1:0] lut_q [8];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALT: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = bus.StartAddr;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!bus.Stall) begin
                    // The halt word is not retired and wins over a branch.
                    if (bus.InstIn == {W{1'b1}}) begin
                        state_d = HALT;
                    end else begin
                        pc_d = bus.BranchTaken ? lut_q[bus.BranchIdx] : pc_q + A'(1);
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == HALT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            // A branch in the same cycle has already read the old entry.
            if (bus.LutWe) begin
                lut_q[bus.LutIdx] <= bus.LutData;
            end
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.InstValid   = busy_q & ~bus.Stall;
    assign bus.InstCount   = cnt_q;

endmodule
